// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, limits and helpers for the I2C register sequencer
package i2c_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam int   I2C_MAX_LEN  = 4;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    // Select byte i of a little-endian 32-bit word.
    function automatic logic [7:0] wbyte(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/i2c_busy_edge.sv
// i2c_busy_edge: registers the master's busy flag and flags its rising and falling edges
module i2c_busy_edge (
    input  logic clk,
    input  logic reset,
    input  logic busy_i,
    output logic busy_q_o,
    output logic rise_o,
    output logic fall_o
);

    logic busy_q;

    // One cycle of busy history for edge detection.
    always_ff @(posedge clk) begin
        if (reset) busy_q <= 1'b0;
        else busy_q <= busy_i;
    end

    assign busy_q_o = busy_q;
    assign rise_o   = busy_i & ~busy_q;
    assign fall_o   = ~busy_i & busy_q;

endmodule

// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: runs complete I2C register writes/reads over the byte-level i2c_master handshake
module i2c_reg_seq
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TO_W        = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [6:0]  req_dev,
    input  logic [7:0]  req_reg,
    input  logic [2:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        rsp_done,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        m_ena,
    output logic [6:0]  m_addr,
    output logic        m_rw,
    output logic [7:0]  m_data_wr,
    input  logic        m_busy,
    input  logic [7:0]  m_data_rd,
    input  logic        m_ack_error
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]      state_q, state_d;
    logic            ena_q, ena_d;
    logic [6:0]      addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [7:0]      dwr_q, dwr_d;
    logic            rrw_q, rrw_d;
    logic [2:0]      len_q, len_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [1:0]      rd_q, rd_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            done_q, rerr_q;
    logic            busy_q, rise, fall;
    logic            timeout, capture;
    logic [2:0]      total;

    i2c_busy_edge u_edge (
        .clk     (clk),
        .reset   (reset),
        .busy_i  (m_busy),
        .busy_q_o(busy_q),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign req_ready = (state_q == IDLE) & ~m_busy & ~busy_q;
    assign total     = len_q + 3'd1;
    assign timeout   = to_q == TO_LAST;
    // Commands after the pointer byte of a read are the data bytes.
    assign capture   = fall & rrw_q & (cmd_q >= 3'd2);

    assign m_ena     = ena_q;
    assign m_addr    = addr_q;
    assign m_rw      = rw_q;
    assign m_data_wr = dwr_q;
    assign rsp_done  = done_q;
    assign rsp_err   = rerr_q;
    assign rsp_rdata = rdata_q;

    // Transaction sequencing: accept, issue commands on each busy rise, collect bytes, finish.
    always_comb begin
        state_d = state_q;
        ena_d   = ena_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        dwr_d   = dwr_q;
        rrw_d   = rrw_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cmd_d   = cmd_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    rrw_d   = req_rw & (req_len != 3'd0);
                    len_d   = req_len;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cmd_d   = '0;
                    rd_d    = '0;
                    err_d   = req_len > 3'(I2C_MAX_LEN);
                    if (req_len > 3'(I2C_MAX_LEN)) begin
                        state_d = RESP;
                    end else begin
                        ena_d   = 1'b1;
                        addr_d  = req_dev;
                        rw_d    = I2C_RW_WRITE;
                        dwr_d   = req_reg;
                        state_d = CMD;
                    end
                end
            end
            CMD: begin
                if (rise) begin
                    cmd_d = cmd_q + 3'd1;
                    if (cmd_q + 3'd1 == total) begin
                        ena_d   = 1'b0;
                        state_d = STOP;
                    end else if (rrw_q) begin
                        rw_d = I2C_RW_READ;
                    end else begin
                        dwr_d = wbyte(wdata_q, cmd_q[1:0]);
                    end
                end
                if (capture) begin
                    rdata_d[{rd_q, 3'b000} +: 8] = m_data_rd;
                    rd_d = rd_q + 2'd1;
                end
                if (fall && m_ack_error) begin
                    ena_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = STOP;
                end
                if (timeout) begin
                    ena_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            STOP: begin
                ena_d = 1'b0;
                if (capture) begin
                    rdata_d[{rd_q, 3'b000} +: 8] = m_data_rd;
                    rd_d = rd_q + 2'd1;
                end
                if (fall && m_ack_error) err_d = 1'b1;
                if (!m_busy && !busy_q) state_d = RESP;
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Watchdog: restarts on any busy edge or state change, runs only while the bus is in use.
    always_comb begin
        to_d = (rise || fall || state_d != state_q || state_q == IDLE || state_q == RESP) ? '0 : to_q + 1'b1;
    end

    // State and registered outputs; the response pulse follows the RESP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ena_q   <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            dwr_q   <= '0;
            rrw_q   <= 1'b0;
            len_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cmd_q   <= '0;
            rd_q    <= '0;
            to_q    <= '0;
            done_q  <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ena_q   <= ena_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            dwr_q   <= dwr_d;
            rrw_q   <= rrw_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            rd_q    <= rd_d;
            to_q    <= to_d;
            done_q  <= state_q == RESP;
            rerr_q  <= (state_q == RESP) & err_q;
        end
    end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: directed checks of the register sequencer against a byte-level master model
module tb_i2c_reg_seq;

    localparam int TO = 500;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [6:0]  req_dev = '0;
    logic [7:0]  req_reg = '0;
    logic [2:0]  req_len = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_done, rsp_err;
    logic [31:0] rsp_rdata;
    logic        m_ena, m_rw;
    logic [6:0]  m_addr;
    logic [7:0]  m_data_wr;
    logic        m_busy = 1'b0;
    logic [7:0]  m_data_rd = 8'h00;
    logic        m_ack_error = 1'b0;

    i2c_reg_seq #(.TIMEOUT_CYC(TO), .TO_W(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .m_ena(m_ena), .m_addr(m_addr), .m_rw(m_rw), .m_data_wr(m_data_wr),
        .m_busy(m_busy), .m_data_rd(m_data_rd), .m_ack_error(m_ack_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Master model state and per-byte log
    int         bstate = 0, bcnt = 0, pulses = 0, rd_ptr = 0;
    int         rise_cyc = 0, fall_cyc = 0;
    int         nack_at = -1;
    logic       stuck = 1'b0;
    logic       lat_rw = 1'b0;
    logic [7:0] rd_bytes [4];
    logic [7:0] log_data [64];
    logic       log_rw   [64];
    logic [6:0] log_addr [64];

    // Master model: busy 90 cycles per byte, 10-cycle gap, continues while ena is high.
    always @(negedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_ack_error = 1'b0;
            bstate = 0;
            bcnt = 0;
        end else begin
            bcnt = bcnt + 1;
            if (bstate == 1 && bcnt >= 90 && !stuck) begin
                m_busy = 1'b0;
                m_data_rd = (lat_rw && rd_ptr < 4) ? rd_bytes[rd_ptr] : 8'h00;
                if (lat_rw) rd_ptr = rd_ptr + 1;
                m_ack_error = (pulses - 1 == nack_at);
                fall_cyc = cyc;
                bstate = 2;
                bcnt = 0;
            end else if (bstate == 0 || (bstate == 2 && bcnt >= 10)) begin
                if (m_ena) begin
                    if (!m_rw) rd_ptr = 0;
                    lat_rw = m_rw;
                    log_data[pulses] = m_data_wr;
                    log_rw[pulses] = m_rw;
                    log_addr[pulses] = m_addr;
                    pulses = pulses + 1;
                    m_busy = 1'b1;
                    m_ack_error = 1'b0;
                    rise_cyc = cyc;
                    bstate = 1;
                    bcnt = 0;
                end else begin
                    bstate = 0;
                end
            end
        end
    end

    int checks = 0, errors = 0;
    int base = 0, ena_low = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [2:0] len, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        req_rw = rw; req_dev = dev; req_reg = rg; req_len = len; req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (!rsp_done && n < max) begin
            @(negedge clk);
            n++;
            if (!m_ena && ena_low < 0) ena_low = cyc;
        end
        check(tag, rsp_done, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst ready", req_ready, 1);
        check("rst outs", {m_ena, m_addr, m_rw, m_data_wr, rsp_done, rsp_err}, 0);
        check("rst rdata", rsp_rdata, 0);

        // write 2 bytes
        base = pulses;
        send(1'b0, 7'h68, 8'h0E, 3'd2, 32'h0000_1C05);
        check("wr ena", m_ena, 1);
        check("wr addr", m_addr, 7'h68);
        wait_done("wr done", 2000);
        check("wr err", rsp_err, 0);
        repeat (30) @(negedge clk);
        check("wr pulses", pulses - base, 3);
        check("wr b0", log_data[base], 8'h0E);
        check("wr b1", log_data[base+1], 8'h05);
        check("wr b2", log_data[base+2], 8'h1C);
        check("wr rw", {log_rw[base], log_rw[base+1], log_rw[base+2]}, 0);

        // read 3 bytes
        rd_bytes[0] = 8'h12; rd_bytes[1] = 8'h34; rd_bytes[2] = 8'h56; rd_bytes[3] = 8'h78;
        base = pulses;
        send(1'b1, 7'h68, 8'h00, 3'd3, 32'h0);
        wait_done("rd done", 2000);
        check("rd err", rsp_err, 0);
        check("rd data", rsp_rdata, 32'h0056_3412);
        repeat (30) @(negedge clk);
        check("rd pulses", pulses - base, 4);
        check("rd rw", {log_rw[base], log_rw[base+1], log_rw[base+2], log_rw[base+3]}, 4'b0111);
        check("rd ptr", log_data[base], 8'h00);
        check("rd addr", log_addr[base+3], 7'h68);
        check("rd hold", rsp_rdata, 32'h0056_3412);

        // illegal length: response on the second cycle after accept, no bus activity
        base = pulses;
        send(1'b0, 7'h11, 8'h22, 3'd5, 32'hFFFF_FFFF);
        check("ill d1", {rsp_done, m_ena}, 2'b00);
        @(negedge clk);
        check("ill d2", {rsp_done, rsp_err, m_ena}, 3'b110);
        check("ill clr", rsp_rdata, 0);
        @(negedge clk);
        check("ill pulse", rsp_done, 0);
        repeat (20) @(negedge clk);
        check("ill pulses", pulses - base, 0);

        // read with len 0 is a pointer-only write
        base = pulses;
        send(1'b1, 7'h68, 8'h07, 3'd0, 32'h0);
        wait_done("rd0 done", 2000);
        check("rd0 err", rsp_err, 0);
        repeat (30) @(negedge clk);
        check("rd0 pulses", pulses - base, 1);
        check("rd0 byte", {log_rw[base], log_data[base]}, 9'h007);

        // NACK on the address byte
        base = pulses;
        nack_at = pulses;
        ena_low = -1;
        send(1'b0, 7'h68, 8'h0E, 3'd2, 32'h0000_1C05);
        wait_done("nack done", 2000);
        check("nack err", rsp_err, 1);
        check("nack lag", ena_low - fall_cyc, 1);
        repeat (30) @(negedge clk);
        check("nack pulses", pulses - base, 1);
        nack_at = -1;

        // stuck bus: abort TO clocks after the registered busy edge
        base = pulses;
        stuck = 1'b1;
        ena_low = -1;
        send(1'b0, 7'h50, 8'h01, 3'd1, 32'h0000_00AA);
        wait_done("to done", TO + 400);
        check("to err", rsp_err, 1);
        check("to time", ena_low - rise_cyc, TO + 1);
        repeat (5) @(negedge clk);
        check("to ready", req_ready, 0);
        stuck = 1'b0;
        repeat (30) @(negedge clk);
        check("to free", req_ready, 1);
        check("to pulses", pulses - base, 1);

        // reset during the second read byte
        rd_bytes[0] = 8'hA1; rd_bytes[1] = 8'hB2; rd_bytes[2] = 8'hC3;
        base = pulses;
        send(1'b1, 7'h3C, 8'h20, 3'd3, 32'h0);
        for (int n = 0; n < 2000 && pulses - base < 3; n++) @(negedge clk);
        check("mid pulses", pulses - base, 3);
        repeat (20) @(negedge clk);
        check("mid rdata", rsp_rdata, 32'h0000_00A1);
        check("mid rw", m_rw, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid outs", {m_ena, m_addr, m_rw, m_data_wr, rsp_done, rsp_err}, 0);
        check("mid rdclr", rsp_rdata, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        base = pulses;
        send(1'b0, 7'h50, 8'h10, 3'd1, 32'h0000_00AB);
        wait_done("post done", 2000);
        check("post err", rsp_err, 0);
        repeat (30) @(negedge clk);
        check("post pulses", pulses - base, 2);
        check("post b0", {log_addr[base], log_data[base]}, {7'h50, 8'h10});
        check("post b1", log_data[base+1], 8'hAB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
